// File: rtl/uart_cmd_responder_if.sv
// Link bundle for uart_cmd_responder: rx-FIFO read port, tx-FIFO write port
// and the local register bus, all on sys_clk.
interface uart_cmd_responder_if;
    logic [7:0]  rx_data;
    logic        rx_req;
    logic        rx_permitted;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_permitted;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output rx_req, tx_data, tx_valid,
        output bus_addr, bus_wdata, bus_wr, bus_rd,
        input  rx_data, rx_permitted, tx_permitted,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  rx_req, tx_data, tx_valid,
        input  bus_addr, bus_wdata, bus_wr, bus_rd,
        output rx_data, rx_permitted, tx_permitted,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Host-link command responder: parses frames, runs one bus access, replies.
// Optional inter-byte timeout: define UART_CMD_BYTE_TIMEOUT_EN.
module uart_cmd_responder #(
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter logic [7:0] RSP_TAG      = 8'h5A,
    parameter int         BUS_TIMEOUT  = 255,
    parameter int         BYTE_TIMEOUT = 65535
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    uart_cmd_responder_if.master  link,
    output logic [7:0]            err_cnt
);
    typedef enum logic [2:0] {
        S_HUNT, S_OPC, S_ADDR, S_DATA,
        S_CSUM, S_EXEC, S_RSP_STAT, S_RSP_DATA
    } state_t;

    localparam logic [7:0] BUS_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state, state_nx;
    logic        req_q, cap_q;
    logic [7:0]  opc_q, csum_q, csum_rx_q, stat_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  idx_q;
    logic [7:0]  bcnt_q;
    logic        wr_q, rd_q;
    logic [7:0]  err_q;

    logic        in_frame, need_byte, got, busy;
    logic        acked, expired, to_hit, fetch;
    logic        err_inc, last_byte;
    logic [7:0]  byte_in, stat_nx;

    assign byte_in   = link.rx_data;
    assign in_frame  = state inside {S_OPC, S_ADDR, S_DATA, S_CSUM};
    assign need_byte = in_frame || state == S_HUNT;
    assign busy      = wr_q | rd_q;
    assign acked     = busy & link.bus_ack;
    assign expired   = busy & ~link.bus_ack & (bcnt_q == BUS_LAST);
    assign last_byte = (idx_q == 2'd3);
    assign fetch     = need_byte & link.rx_permitted & ~req_q & ~cap_q;

`ifdef UART_CMD_BYTE_TIMEOUT_EN
    localparam logic [15:0] BYTE_LAST = 16'(BYTE_TIMEOUT);
    logic [15:0] idle_q;
    logic        drop_q;

    assign to_hit = in_frame & (idle_q >= BYTE_LAST);
    assign got    = cap_q & ~drop_q & ~to_hit;

    // a fetch in flight at timeout still lands; its byte is thrown away
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q <= '0;
            drop_q <= 1'b0;
        end else begin
            if (!in_frame || cap_q || to_hit)
                idle_q <= '0;
            else
                idle_q <= idle_q + 16'd1;
            if (to_hit && req_q)
                drop_q <= 1'b1;
            else if (cap_q)
                drop_q <= 1'b0;
        end
    end
`else
    assign to_hit = 1'b0;
    assign got    = cap_q;
`endif

    always_comb begin
        stat_nx = 8'h00;
        if (byte_in != csum_q)
            stat_nx = 8'h01;
        else if (opc_q != 8'h01 && opc_q != 8'h02)
            stat_nx = 8'h02;
    end

    assign err_inc = (state == S_CSUM && got && stat_nx != 8'h00)
                   || expired || to_hit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= S_HUNT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        link.tx_valid = 1'b0;
        link.tx_data  = '0;
        unique case (state)
            S_HUNT:
                if (got && byte_in == HDR_BYTE) state_nx = S_OPC;
            S_OPC:
                if (got) state_nx = S_ADDR;
            S_ADDR:
                if (got && last_byte)
                    state_nx = (opc_q == 8'h01) ? S_DATA : S_CSUM;
            S_DATA:
                if (got && last_byte) state_nx = S_CSUM;
            S_CSUM:
                if (got) state_nx = S_EXEC;
            S_EXEC:
                if (!busy || acked || expired) state_nx = S_RSP_STAT;
            S_RSP_STAT: begin
                link.tx_data  = {RSP_TAG, opc_q, stat_q, csum_rx_q};
                link.tx_valid = link.tx_permitted;
                if (link.tx_permitted)
                    state_nx = (opc_q == 8'h02 && stat_q == 8'h00)
                             ? S_RSP_DATA : S_HUNT;
            end
            S_RSP_DATA: begin
                link.tx_data  = rdata_q;
                link.tx_valid = link.tx_permitted;
                if (link.tx_permitted) state_nx = S_HUNT;
            end
            default: state_nx = S_HUNT;
        endcase
        if (to_hit) state_nx = S_HUNT;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_q     <= 1'b0;
            cap_q     <= 1'b0;
            opc_q     <= '0;
            csum_q    <= '0;
            csum_rx_q <= '0;
            stat_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= '0;
        end else begin
            req_q <= fetch;
            cap_q <= req_q;
            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
            if (got) begin
                case (state)
                    S_OPC: begin
                        opc_q  <= byte_in;
                        csum_q <= byte_in;
                        idx_q  <= 2'd0;
                    end
                    S_ADDR: begin
                        addr_q <= {addr_q[23:0], byte_in};
                        csum_q <= csum_q ^ byte_in;
                        idx_q  <= idx_q + 2'd1;
                    end
                    S_DATA: begin
                        wdata_q <= {wdata_q[23:0], byte_in};
                        csum_q  <= csum_q ^ byte_in;
                        idx_q   <= idx_q + 2'd1;
                    end
                    S_CSUM: begin
                        csum_rx_q <= byte_in;
                        stat_q    <= stat_nx;
                        bcnt_q    <= '0;
                        wr_q <= (stat_nx == 8'h00) && (opc_q == 8'h01);
                        rd_q <= (stat_nx == 8'h00) && (opc_q == 8'h02);
                    end
                    default: ;
                endcase
            end
            // ack on the final timeout cycle wins over the abort
            if (busy) begin
                if (acked) begin
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    rdata_q <= link.bus_rdata;
                end else if (expired) begin
                    wr_q   <= 1'b0;
                    rd_q   <= 1'b0;
                    stat_q <= 8'h03;
                end else begin
                    bcnt_q <= bcnt_q + 8'd1;
                end
            end
        end
    end

    assign link.rx_req    = req_q;
    assign link.bus_addr  = addr_q;
    assign link.bus_wdata = wdata_q;
    assign link.bus_wr    = wr_q;
    assign link.bus_rd    = rd_q;
    assign err_cnt        = err_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: random frames vs a frame-level model.
// Define UART_CMD_BYTE_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_uart_cmd_responder;
    localparam int BUS_TO = 255;
`ifdef UART_CMD_BYTE_TIMEOUT_EN
    localparam int BYTE_TO = 100;
`else
    localparam int BYTE_TO = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] err_cnt;

    uart_cmd_responder_if link();

    uart_cmd_responder #(
        .BUS_TIMEOUT (BUS_TO),
        .BYTE_TIMEOUT(BYTE_TO)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .link     (link),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cycles;
    } bus_t;

    logic [31:0] tx_exp[$];
    bus_t        bus_exp[$];
    logic [7:0]  rx_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_tx = 0;
    int          ack_lat = 0;
    logic [31:0] rd_val = '0;
    bit          tx_block = 1'b0;
    logic [7:0]  err_exp = '0;
    bit          pend = 1'b0;
    logic [7:0]  pend_byte;
    int          hi = 0;
    bit          prev_busy = 1'b0;
    int          busy_cyc = 0;
    bus_t        cur;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // FIFO, bus slave and tx-room models
    always @(posedge clk) begin
        #1;
        if (pend) begin
            link.rx_data = pend_byte;
            pend = 1'b0;
        end
        link.rx_permitted = (rx_q.size() != 0) && ($urandom_range(3) != 0);
        link.tx_permitted = !tx_block && ($urandom_range(3) != 0);
        if (link.bus_wr || link.bus_rd) begin
            link.bus_ack   = (hi == ack_lat);
            link.bus_rdata = (hi == ack_lat) ? rd_val : $urandom;
            hi++;
        end else begin
            link.bus_ack   = ($urandom_range(7) == 0);
            link.bus_rdata = $urandom;
            hi = 0;
        end
    end

    // monitor: rx pops, tx scoreboard, bus scoreboard
    always @(negedge clk) begin
        bit busy;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (link.rx_req) begin
                if (rx_q.size() == 0) fail("rx_underflow");
                else begin
                    pend_byte = rx_q.pop_front();
                    pend = 1'b1;
                end
            end
            if (link.tx_valid) begin
                n_tx++;
                if (tx_exp.size() == 0)
                    check("tx_unexpected", link.tx_data, 32'hxxxxxxxx);
                else
                    check("tx_word", link.tx_data, tx_exp.pop_front());
            end
            busy = link.bus_wr || link.bus_rd;
            if (busy && !prev_busy) begin
                busy_cyc = 0;
                if (bus_exp.size() == 0) fail("bus_unexpected");
                else begin
                    cur = bus_exp.pop_front();
                    check("bus_wr", 32'(link.bus_wr), 32'(cur.wr));
                    check("bus_rd", 32'(link.bus_rd), 32'(!cur.wr));
                    check("bus_addr", link.bus_addr, cur.addr);
                    if (cur.wr) check("bus_wdata", link.bus_wdata, cur.wdata);
                end
            end
            if (busy) busy_cyc++;
            if (!busy && prev_busy) check("bus_len", busy_cyc, cur.cycles);
            prev_busy = busy;
        end
    end

    task automatic check_reset_outputs();
        check("rst_rx_req", 32'(link.rx_req), 0);
        check("rst_tx_valid", 32'(link.tx_valid), 0);
        check("rst_bus_wr", 32'(link.bus_wr), 0);
        check("rst_bus_rd", 32'(link.bus_rd), 0);
        check("rst_tx_data", link.tx_data, 0);
        check("rst_bus_addr", link.bus_addr, 0);
        check("rst_bus_wdata", link.bus_wdata, 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
    endtask

    // csx < 0: correct checksum, else the checksum byte actually sent
    task automatic run_frame(int ngarb, logic [7:0] opc, logic [31:0] addr,
                             logic [31:0] data, int csx, int lat,
                             logic [31:0] rdv, int hold);
        logic [7:0] b[$];
        logic [7:0] cs, cs_rx, st, g;
        int         k, n0;
        for (int i = 0; i < ngarb; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h3C;
            b.push_back(g);
        end
        b.push_back(8'hA5);
        b.push_back(opc);
        cs = opc;
        for (int i = 3; i >= 0; i--) begin
            b.push_back(addr[8*i +: 8]);
            cs ^= addr[8*i +: 8];
        end
        if (opc == 8'h01)
            for (int i = 3; i >= 0; i--) begin
                b.push_back(data[8*i +: 8]);
                cs ^= data[8*i +: 8];
            end
        cs_rx = (csx < 0) ? cs : 8'(csx);
        b.push_back(cs_rx);
        if (cs_rx != cs) st = 8'h01;
        else if (opc != 8'h01 && opc != 8'h02) st = 8'h02;
        else if (lat >= BUS_TO) st = 8'h03;
        else st = 8'h00;
        if (st == 8'h00 || st == 8'h03)
            bus_exp.push_back('{opc == 8'h01, addr, data,
                                (st == 8'h03) ? BUS_TO : lat + 1});
        tx_exp.push_back({8'h5A, opc, st, cs_rx});
        if (opc == 8'h02 && st == 8'h00) tx_exp.push_back(rdv);
        if (st != 8'h00 && err_exp != 8'hFF) err_exp++;
        ack_lat = lat;
        rd_val = rdv;
        n0 = n_tx;
        if (hold > 0) tx_block = 1'b1;
        foreach (b[i]) rx_q.push_back(b[i]);
        if (hold > 0) begin
            k = 0;
            while ((rx_q.size() != 0 || bus_exp.size() != 0 || prev_busy)
                   && k < 2000) begin
                @(negedge clk);
                k++;
            end
            repeat (hold) @(negedge clk);
            check("tx_held", n_tx - n0, 0);
            tx_block = 1'b0;
        end
        k = 0;
        while (tx_exp.size() != 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) begin
            fail("frame_timeout");
            tx_exp.delete();
            bus_exp.delete();
            rx_q.delete();
        end
        repeat (4) @(negedge clk);
        if (hold > 0) check("tx_once", n_tx - n0, 1);
        check("err_cnt", 32'(err_cnt), 32'(err_exp));
    endtask

    initial begin
        int opc_sel, lat;
        logic [7:0] opc;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // directed frames from the frame-format examples
        run_frame(0, 8'h01, 32'h10, 32'hDEADBEEF, -1, 3, '0, 0);
        run_frame(0, 8'h02, 32'h20, '0, -1, 2, 32'h12345678, 0);
        run_frame(3, 8'h02, 32'h44, '0, -1, 0, 32'hCAFEF00D, 0);
        run_frame(0, 8'h01, 32'h10, 32'hDEADBEEF, 8'h00, 3, '0, 0);
        run_frame(0, 8'h07, 32'h10, '0, -1, 3, '0, 0);
        run_frame(0, 8'h02, 32'h30, '0, -1, 1000, '0, 0);
        run_frame(0, 8'h02, 32'h34, '0, -1, BUS_TO - 1, 32'h0BAD_F00D, 0);
        run_frame(0, 8'h01, 32'hA5A5A5A5, 32'hA5000000, -1, 0, '0, 0);
        run_frame(1, 8'h01, 32'h50, 32'h1, -1, 3, '0, 50);

        // reset in the middle of a frame
        foreach (rx_q[i]) rx_q[i] = 8'h00;
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h00);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx_q.delete();
        pend = 1'b0;
        err_exp = '0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 8'h02, 32'h60, '0, -1, 1, 32'h600DD00D, 0);

`ifdef UART_CMD_BYTE_TIMEOUT_EN
        begin
            int n0;
            n0 = n_tx;
            rx_q.push_back(8'hA5);
            rx_q.push_back(8'h01);
            rx_q.push_back(8'h00);
            rx_q.push_back(8'h00);
            repeat (250) @(negedge clk);
            if (err_exp != 8'hFF) err_exp++;
            check("byte_to_err", 32'(err_cnt), 32'(err_exp));
            check("byte_to_notx", n_tx - n0, 0);
            run_frame(0, 8'h02, 32'h70, '0, -1, 2, 32'h7777AAAA, 0);
        end
`endif

        for (int f = 0; f < 150; f++) begin
            opc_sel = $urandom_range(19);
            opc = (opc_sel < 9) ? 8'h01 : (opc_sel < 18) ? 8'h02 : 8'($urandom);
            lat = $urandom_range(99);
            lat = (lat < 4) ? 1000 : (lat < 7) ? BUS_TO - 1 : $urandom_range(6);
            run_frame($urandom_range(2), opc, $urandom, $urandom,
                      ($urandom_range(6) == 0) ? int'($urandom_range(255)) : -1,
                      lat, $urandom, 0);
        end

        // drive the error counter into saturation
        for (int f = 0; f < 260; f++)
            run_frame(0, 8'h02, $urandom, '0, -1 + 0 * f == -1 ? 8'h00 : 8'h00,
                      0, '0, 0);
        check("err_sat", 32'(err_cnt), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command-side peer of the UART bridge: it is the responder for the host link.
- Pulls received bytes from the bridge's receive-FIFO read port and parses fixed-format command frames.
- Executes each valid frame as a single 32-bit write or read on a simple local register bus.
- Returns 32-bit response words through the bridge's transmit-FIFO write port; all logic runs on sys_clk.

Parameters:
- HDR_BYTE, 8'hA5, frame start byte.
- RSP_TAG, 8'h5A, tag in bits [31:24] of every status word.
- BUS_TIMEOUT, 255, max cycles waiting for bus_ack before aborting (8-bit counter).
- BYTE_TIMEOUT, 65535, max idle cycles between frame bytes (optional feature only; 16-bit counter).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from receive FIFO, valid the cycle after rx_req
- rx_req  out  1  receive-FIFO read request, one-cycle pulse
- rx_permitted  in  1  receive FIFO non-empty
- tx_data  out  32  response word to transmit FIFO
- tx_valid  out  1  write strobe, one-cycle pulse per word
- tx_permitted  in  1  transmit FIFO has room
- bus_addr  out  32  register bus address
- bus_wdata  out  32  register bus write data
- bus_wr  out  1  write request, held until bus_ack or timeout
- bus_rd  out  1  read request, held until bus_ack or timeout
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion
- err_cnt  out  8  saturating count of rejected or aborted frames

Behaviour:
- Reset values: rx_req, tx_valid, bus_wr, bus_rd = 0; tx_data, bus_addr, bus_wdata, err_cnt = 0; state = HUNT.
- Reset mid-frame discards all partial state immediately.

Frame format:
- Byte order: HDR_BYTE, OPC, A3, A2, A1, A0, then D3, D2, D1, D0 (only when OPC=8'h01), then CSUM. MSB first.
- CSUM = XOR of OPC and all address and data bytes.

Byte fetch:
- rx_req pulses only when rx_permitted=1, the state needs a byte, and no fetch is outstanding.
- The byte is captured on the cycle after rx_req, so throughput is at most one byte per 2 cycles.

States:
- HUNT: fetch bytes; any byte other than HDR_BYTE is discarded silently → OPC on HDR_BYTE.
- OPC: capture opcode, init checksum = OPC → ADDR.
- ADDR: 4 bytes, shifted in MSB first, XORed into the checksum → DATA if OPC=01, else CSUM.
- DATA: 4 bytes, same handling → CSUM.
- CSUM: compare the received byte with the computed XOR → EXEC.
  - Mismatch: status 8'h01, skip bus.
  - OPC not in {01, 02}: status 8'h02, skip bus (checksum checked first).
- EXEC: assert bus_wr (OPC 01) or bus_rd (OPC 02) with bus_addr/bus_wdata stable.
  - On bus_ack: deassert the cycle after and capture bus_rdata; status 8'h00.
  - After BUS_TIMEOUT cycles without ack: deassert; status 8'h03.
  - → RSP_STAT.
- RSP_STAT: wait for tx_permitted=1, then pulse tx_valid with tx_data = {RSP_TAG, OPC, status, CSUM_rx}.
  - → RSP_DATA if OPC=02 and status=00, else HUNT.
- RSP_DATA: wait for tx_permitted, pulse tx_valid with the captured read data → HUNT.

Error counting:
- err_cnt increments by 1 for every nonzero status, saturating at 8'hFF.
- Never clears except on reset.

Boundary and timing rules:
- HDR_BYTE appearing inside a frame is treated as data, with no resync.
- bus_ack arriving while the bus is idle is ignored.
- bus_ack on the same cycle the timeout expires counts as success.
- A nonzero status is always reported, even when the bus was skipped.
- Latency from the CSUM byte captured to tx_valid: EXEC cycles + 1 when tx_permitted=1.

Optional Feature:
- Macro: UART_CMD_BYTE_TIMEOUT_EN.
- Defined:
  - In OPC/ADDR/DATA/CSUM, a counter counts cycles since the last captured byte.
  - When it reaches BYTE_TIMEOUT, the partial frame is dropped, err_cnt increments, the FSM returns to HUNT, and no response is sent.
  - An outstanding fetch completes first and its byte is discarded.
- Undefined: no counter; the FSM waits in any frame state indefinitely.

Test Plan:
- Write frame A5 01 00 00 00 10 DE AD BE EF, CSUM=01^10^DE^AD^BE^EF, bus acks after 3 cycles → bus_wr with addr 0x10, wdata 0xDEADBEEF; one tx word {5A,01,00,CSUM}; err_cnt=0.
- Read frame A5 02 00 00 00 20 CSUM=22, bus_rdata=0x12345678 → tx words {5A,02,00,22} then 0x12345678.
- Leading garbage 00 FF 3C before a valid read frame → garbage silently dropped, normal response, err_cnt=0.
- Write frame with CSUM corrupted to 00 → no bus_wr; tx {5A,01,01,00}; err_cnt=1. Opcode 07 with a correct checksum → status 02, err_cnt=2.
- Read with bus_ack never asserted → bus_rd high for exactly BUS_TIMEOUT cycles; tx {5A,02,03,CSUM} and no data word.
- tx_permitted held 0 for 50 cycles during RSP_STAT → no tx_valid until it rises, then exactly one pulse. With UART_CMD_BYTE_TIMEOUT_EN, BYTE_TIMEOUT=100 and a frame stalled after A2 → HUNT after 100 idle cycles, err_cnt +1, no tx.
